// File: rtl/ysyx_23060025_axi_rd_arbiter.sv
// ysyx_23060025_axi_rd_arbiter: IFU/LSU AXI4-Lite read-channel arbiter.
// One read outstanding at a time; LSU wins when both request together.
module ysyx_23060025_axi_rd_arbiter #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                rstn,

  input  logic [ADDR_LEN-1:0] ifu_ar_addr_i,
  input  logic                ifu_ar_valid_i,
  output logic                ifu_ar_ready_o,
  output logic [DATA_LEN-1:0] ifu_r_data_o,
  output logic [1:0]          ifu_r_resp_o,
  output logic                ifu_r_valid_o,
  input  logic                ifu_r_ready_i,

  input  logic [ADDR_LEN-1:0] lsu_ar_addr_i,
  input  logic [2:0]          lsu_ar_size_i,
  input  logic                lsu_ar_valid_i,
  output logic                lsu_ar_ready_o,
  output logic [DATA_LEN-1:0] lsu_r_data_o,
  output logic [1:0]          lsu_r_resp_o,
  output logic                lsu_r_valid_o,
  input  logic                lsu_r_ready_i,

  output logic [ADDR_LEN-1:0] out_ar_addr_o,
  output logic [2:0]          out_ar_size_o,
  output logic                out_ar_valid_o,
  input  logic                out_ar_ready_i,
  input  logic [DATA_LEN-1:0] out_r_data_i,
  input  logic [1:0]          out_r_resp_i,
  input  logic                out_r_valid_i,
  output logic                out_r_ready_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFU_AR = 3'd1,
    IFU_R  = 3'd2,
    LSU_AR = 3'd3,
    LSU_R  = 3'd4
  } state_t;

  localparam logic [2:0] IFU_SIZE = 3'b010;

  state_t state_q;
  state_t state_d;

  logic in_ifu_ar;
  logic in_ifu_r;
  logic in_lsu_ar;
  logic in_lsu_r;

  logic ifu_ar_hs;
  logic lsu_ar_hs;
  logic ifu_r_hs;
  logic lsu_r_hs;

  assign in_ifu_ar = (state_q == IFU_AR);
  assign in_ifu_r  = (state_q == IFU_R);
  assign in_lsu_ar = (state_q == LSU_AR);
  assign in_lsu_r  = (state_q == LSU_R);

  assign ifu_ar_hs = in_ifu_ar & ifu_ar_valid_i & out_ar_ready_i;
  assign lsu_ar_hs = in_lsu_ar & lsu_ar_valid_i & out_ar_ready_i;
  assign ifu_r_hs  = in_ifu_r & out_r_valid_i & ifu_r_ready_i;
  assign lsu_r_hs  = in_lsu_r & out_r_valid_i & lsu_r_ready_i;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A waiting master simply keeps its valid high until IDLE comes back.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_ar_valid_i) begin
          state_d = LSU_AR;
        end else if (ifu_ar_valid_i) begin
          state_d = IFU_AR;
        end
      end
      IFU_AR: if (ifu_ar_hs) state_d = IFU_R;
      IFU_R:  if (ifu_r_hs)  state_d = IDLE;
      LSU_AR: if (lsu_ar_hs) state_d = LSU_R;
      LSU_R:  if (lsu_r_hs)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ifu_ar_ready_o = 1'b0;
    ifu_r_data_o   = '0;
    ifu_r_resp_o   = 2'b00;
    ifu_r_valid_o  = 1'b0;
    lsu_ar_ready_o = 1'b0;
    lsu_r_data_o   = '0;
    lsu_r_resp_o   = 2'b00;
    lsu_r_valid_o  = 1'b0;
    out_ar_addr_o  = '0;
    out_ar_size_o  = 3'b000;
    out_ar_valid_o = 1'b0;
    out_r_ready_o  = 1'b0;
    unique case (1'b1)
      in_ifu_ar: begin
        out_ar_addr_o  = ifu_ar_addr_i;
        out_ar_size_o  = IFU_SIZE;
        out_ar_valid_o = ifu_ar_valid_i;
        ifu_ar_ready_o = out_ar_ready_i;
      end
      in_lsu_ar: begin
        out_ar_addr_o  = lsu_ar_addr_i;
        out_ar_size_o  = lsu_ar_size_i;
        out_ar_valid_o = lsu_ar_valid_i;
        lsu_ar_ready_o = out_ar_ready_i;
      end
      in_ifu_r: begin
        out_r_ready_o = ifu_r_ready_i;
        ifu_r_valid_o = out_r_valid_i;
        ifu_r_data_o  = out_r_data_i;
        ifu_r_resp_o  = out_r_resp_i;
      end
      in_lsu_r: begin
        out_r_ready_o = lsu_r_ready_i;
        lsu_r_valid_o = out_r_valid_i;
        lsu_r_data_o  = out_r_data_i;
        lsu_r_resp_o  = out_r_resp_i;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060025_axi_rd_arbiter.sv
// tb_ysyx_23060025_axi_rd_arbiter: scoreboard bench for the read arbiter.
// Inputs change on negedge; outputs sampled 1 time unit later.
module tb_ysyx_23060025_axi_rd_arbiter;

  logic        clock;
  logic        rstn;
  logic [31:0] ifu_ar_addr;
  logic        ifu_ar_valid;
  logic        ifu_ar_ready;
  logic [31:0] ifu_r_data;
  logic [1:0]  ifu_r_resp;
  logic        ifu_r_valid;
  logic        ifu_r_ready;
  logic [31:0] lsu_ar_addr;
  logic [2:0]  lsu_ar_size;
  logic        lsu_ar_valid;
  logic        lsu_ar_ready;
  logic [31:0] lsu_r_data;
  logic [1:0]  lsu_r_resp;
  logic        lsu_r_valid;
  logic        lsu_r_ready;
  logic [31:0] out_ar_addr;
  logic [2:0]  out_ar_size;
  logic        out_ar_valid;
  logic        out_ar_ready;
  logic [31:0] out_r_data;
  logic [1:0]  out_r_resp;
  logic        out_r_valid;
  logic        out_r_ready;

  ysyx_23060025_axi_rd_arbiter #(
    .ADDR_LEN(32),
    .DATA_LEN(32)
  ) dut (
    .clock          (clock),
    .rstn           (rstn),
    .ifu_ar_addr_i  (ifu_ar_addr),
    .ifu_ar_valid_i (ifu_ar_valid),
    .ifu_ar_ready_o (ifu_ar_ready),
    .ifu_r_data_o   (ifu_r_data),
    .ifu_r_resp_o   (ifu_r_resp),
    .ifu_r_valid_o  (ifu_r_valid),
    .ifu_r_ready_i  (ifu_r_ready),
    .lsu_ar_addr_i  (lsu_ar_addr),
    .lsu_ar_size_i  (lsu_ar_size),
    .lsu_ar_valid_i (lsu_ar_valid),
    .lsu_ar_ready_o (lsu_ar_ready),
    .lsu_r_data_o   (lsu_r_data),
    .lsu_r_resp_o   (lsu_r_resp),
    .lsu_r_valid_o  (lsu_r_valid),
    .lsu_r_ready_i  (lsu_r_ready),
    .out_ar_addr_o  (out_ar_addr),
    .out_ar_size_o  (out_ar_size),
    .out_ar_valid_o (out_ar_valid),
    .out_ar_ready_i (out_ar_ready),
    .out_r_data_i   (out_r_data),
    .out_r_resp_i   (out_r_resp),
    .out_r_valid_i  (out_r_valid),
    .out_r_ready_o  (out_r_ready)
  );

  typedef struct packed {
    logic        lsu;
    logic [31:0] addr;
    logic [2:0]  size;
  } ar_t;

  typedef struct packed {
    logic        lsu;
    logic [31:0] data;
    logic [1:0]  resp;
  } r_t;

  ar_t ar_q[$];
  r_t  r_q[$];
  int  vecs;
  int  errs;

  localparam logic [37:0] AR_RDY_MASK = {1'b1, 2'b00, 35'h7_FFFF_FFFF};
  localparam logic [70:0] R_RDY_MASK  = {2'b11, 1'b0, 68'hF_FFFF_FFFF_FFFF_FFFF};

  logic [108:0] all_out;
  logic [37:0]  ar_obs;
  logic [70:0]  r_obs;

  assign all_out = {ifu_ar_ready, ifu_r_data, ifu_r_resp, ifu_r_valid,
                    lsu_ar_ready, lsu_r_data, lsu_r_resp, lsu_r_valid,
                    out_ar_addr, out_ar_size, out_ar_valid, out_r_ready};
  assign ar_obs = {out_ar_valid, lsu_ar_ready, ifu_ar_ready,
                   out_ar_addr, out_ar_size};
  assign r_obs = {lsu_r_valid, ifu_r_valid, out_r_ready,
                  lsu_r_data, ifu_r_data, lsu_r_resp, ifu_r_resp};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [37:0] ar_exp(ar_t e);
    return {1'b1, e.lsu, ~e.lsu, e.addr, e.size};
  endfunction

  function automatic logic [70:0] r_exp(r_t e);
    return {e.lsu, ~e.lsu, 1'b1,
            e.lsu ? e.data : 32'h0, e.lsu ? 32'h0 : e.data,
            e.lsu ? e.resp : 2'b00, e.lsu ? 2'b00 : e.resp};
  endfunction

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    ifu_ar_addr  = '0;
    ifu_ar_valid = 1'b0;
    ifu_r_ready  = 1'b0;
    lsu_ar_addr  = '0;
    lsu_ar_size  = '0;
    lsu_ar_valid = 1'b0;
    lsu_r_ready  = 1'b0;
    out_ar_ready = 1'b0;
    out_r_data   = '0;
    out_r_resp   = '0;
    out_r_valid  = 1'b0;
  endtask

  task automatic test_reset();
    ar_t ea;
    rstn = 1'b0;
    ifu_ar_addr  = '1;
    ifu_ar_valid = 1'b1;
    ifu_r_ready  = 1'b1;
    lsu_ar_addr  = '1;
    lsu_ar_size  = '1;
    lsu_ar_valid = 1'b1;
    lsu_r_ready  = 1'b1;
    out_ar_ready = 1'b1;
    out_r_data   = '1;
    out_r_resp   = '1;
    out_r_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      vecs++;
      if (all_out !== '0) begin
        errs++;
        $display("FAIL reset_hold[%0d]: outputs %h, want 0", i, all_out);
      end
    end
    @(negedge clock);
    rstn = 1'b1;
    ar_q.push_back('{lsu: 1'b1, addr: 32'hFFFF_FFFF, size: 3'b111});
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL reset_release: outputs %h, want 0", all_out);
    end
    cyc();
    #1;
    vecs++;
    if (ar_q.size() == 0) begin
      errs++;
      $display("FAIL reset_grant: scoreboard empty at AR handshake");
    end else begin
      ea = ar_q.pop_front();
      if (ar_obs !== ar_exp(ea)) begin
        errs++;
        $display("FAIL reset_grant: got %h, want %h", ar_obs, ar_exp(ea));
      end
    end
    rstn = 1'b0;
    idle_inputs();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic test_ifu_alone();
    ar_t ea;
    r_t  er;
    ifu_ar_addr  = 32'h3000_0000;
    ifu_ar_valid = 1'b1;
    out_ar_ready = 1'b1;
    ar_q.push_back('{lsu: 1'b0, addr: 32'h3000_0000, size: 3'b010});
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL ifu_idle: outputs %h, want 0", all_out);
    end
    cyc();
    #1;
    vecs++;
    if (ar_q.size() == 0) begin
      errs++;
      $display("FAIL ifu_ar: scoreboard empty at AR handshake");
    end else begin
      ea = ar_q.pop_front();
      if (ar_obs !== ar_exp(ea)) begin
        errs++;
        $display("FAIL ifu_ar: got %h, want %h", ar_obs, ar_exp(ea));
      end
    end
    cyc();
    ifu_ar_valid = 1'b0;
    ifu_r_ready  = 1'b1;
    out_r_valid  = 1'b1;
    out_r_data   = 32'hDEAD_BEEF;
    out_r_resp   = 2'b00;
    r_q.push_back('{lsu: 1'b0, data: 32'hDEAD_BEEF, resp: 2'b00});
    #1;
    vecs++;
    if (r_q.size() == 0) begin
      errs++;
      $display("FAIL ifu_r: scoreboard empty at R handshake");
    end else begin
      er = r_q.pop_front();
      if (r_obs !== r_exp(er)) begin
        errs++;
        $display("FAIL ifu_r: got %h, want %h", r_obs, r_exp(er));
      end
    end
    cyc();
    idle_inputs();
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL ifu_done: outputs %h, want 0 after 3 cycles", all_out);
    end
  endtask

  task automatic test_simultaneous();
    ar_t ea;
    r_t  er;
    logic [31:0] dat [2];
    dat[0] = 32'h1234_5678;
    dat[1] = 32'h0BAD_F00D;
    ifu_ar_addr  = 32'h3000_0004;
    ifu_ar_valid = 1'b1;
    lsu_ar_addr  = 32'h0F00_0010;
    lsu_ar_size  = 3'b000;
    lsu_ar_valid = 1'b1;
    out_ar_ready = 1'b1;
    ar_q.push_back('{lsu: 1'b1, addr: 32'h0F00_0010, size: 3'b000});
    ar_q.push_back('{lsu: 1'b0, addr: 32'h3000_0004, size: 3'b010});
    for (int m = 0; m < 2; m++) begin
      #1;
      vecs++;
      if (all_out !== '0) begin
        errs++;
        $display("FAIL sim_idle[%0d]: outputs %h, want 0", m, all_out);
      end
      cyc();
      #1;
      vecs++;
      if (ar_q.size() == 0) begin
        errs++;
        $display("FAIL sim_ar[%0d]: scoreboard empty", m);
      end else begin
        ea = ar_q.pop_front();
        if (ar_obs !== ar_exp(ea)) begin
          errs++;
          $display("FAIL sim_ar[%0d]: got %h, want %h", m, ar_obs, ar_exp(ea));
        end
      end
      cyc();
      if (m == 0) lsu_ar_valid = 1'b0;
      else ifu_ar_valid = 1'b0;
      lsu_r_ready = 1'b1;
      ifu_r_ready = 1'b1;
      out_r_valid = 1'b1;
      out_r_data  = dat[m];
      out_r_resp  = 2'b00;
      r_q.push_back('{lsu: (m == 0), data: dat[m], resp: 2'b00});
      #1;
      vecs++;
      if (r_q.size() == 0) begin
        errs++;
        $display("FAIL sim_r[%0d]: scoreboard empty", m);
      end else begin
        er = r_q.pop_front();
        if ({r_obs, ifu_ar_ready} !== {r_exp(er), 1'b0}) begin
          errs++;
          $display("FAIL sim_r[%0d]: got %h/%b, want %h/0", m, r_obs, ifu_ar_ready, r_exp(er));
        end
      end
      cyc();
      out_r_valid = 1'b0;
      lsu_r_ready = 1'b0;
      ifu_r_ready = 1'b0;
    end
    idle_inputs();
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL sim_done: outputs %h, want 0", all_out);
    end
  endtask

  task automatic test_backpressure();
    ar_t ea;
    r_t  er;
    lsu_ar_addr  = 32'h8000_0040;
    lsu_ar_size  = 3'b010;
    lsu_ar_valid = 1'b1;
    out_ar_ready = 1'b0;
    ar_q.push_back('{lsu: 1'b1, addr: 32'h8000_0040, size: 3'b010});
    cyc();
    ifu_ar_addr  = 32'h3000_0100;
    ifu_ar_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      vecs++;
      if (ar_obs !== (ar_exp(ar_q[0]) & AR_RDY_MASK)) begin
        errs++;
        $display("FAIL bp_ar_hold[%0d]: got %h, want %h", i, ar_obs, ar_exp(ar_q[0]) & AR_RDY_MASK);
      end
      cyc();
    end
    out_ar_ready = 1'b1;
    #1;
    vecs++;
    ea = ar_q.pop_front();
    if (ar_obs !== ar_exp(ea)) begin
      errs++;
      $display("FAIL bp_ar: got %h, want %h", ar_obs, ar_exp(ea));
    end
    cyc();
    lsu_ar_valid = 1'b0;
    lsu_r_ready  = 1'b0;
    out_r_valid  = 1'b1;
    out_r_data   = 32'hCAFE_F00D;
    out_r_resp   = 2'b00;
    r_q.push_back('{lsu: 1'b1, data: 32'hCAFE_F00D, resp: 2'b00});
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++;
      if ({r_obs, ar_obs} !== {r_exp(r_q[0]) & R_RDY_MASK, 38'h0}) begin
        errs++;
        $display("FAIL bp_r_hold[%0d]: got %h/%h, want %h/0", i, r_obs, ar_obs, r_exp(r_q[0]) & R_RDY_MASK);
      end
      cyc();
    end
    lsu_r_ready = 1'b1;
    #1;
    vecs++;
    er = r_q.pop_front();
    if (r_obs !== r_exp(er)) begin
      errs++;
      $display("FAIL bp_r: got %h, want %h", r_obs, r_exp(er));
    end
    cyc();
    out_r_valid = 1'b0;
    lsu_r_ready = 1'b0;
    out_ar_ready = 1'b0;
    ar_q.push_back('{lsu: 1'b0, addr: 32'h3000_0100, size: 3'b010});
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL bp_idle: outputs %h, want 0", all_out);
    end
    cyc();
    out_ar_ready = 1'b1;
    #1;
    vecs++;
    ea = ar_q.pop_front();
    if (ar_obs !== ar_exp(ea)) begin
      errs++;
      $display("FAIL bp_ifu_after: got %h, want %h", ar_obs, ar_exp(ea));
    end
    cyc();
    ifu_ar_valid = 1'b0;
    ifu_r_ready  = 1'b1;
    out_r_valid  = 1'b1;
    out_r_data   = 32'h0000_0013;
    cyc();
    idle_inputs();
  endtask

  task automatic test_error();
    ar_t ea;
    r_t  er;
    lsu_ar_addr  = 32'hA000_0000;
    lsu_ar_size  = 3'b001;
    lsu_ar_valid = 1'b1;
    out_ar_ready = 1'b1;
    ar_q.push_back('{lsu: 1'b1, addr: 32'hA000_0000, size: 3'b001});
    cyc();
    #1;
    vecs++;
    ea = ar_q.pop_front();
    if (ar_obs !== ar_exp(ea)) begin
      errs++;
      $display("FAIL err_ar: got %h, want %h", ar_obs, ar_exp(ea));
    end
    cyc();
    lsu_ar_valid = 1'b0;
    lsu_r_ready  = 1'b1;
    out_r_valid  = 1'b1;
    out_r_data   = 32'hBAD0_0BAD;
    out_r_resp   = 2'b10;
    r_q.push_back('{lsu: 1'b1, data: 32'hBAD0_0BAD, resp: 2'b10});
    #1;
    vecs++;
    er = r_q.pop_front();
    if (r_obs !== r_exp(er)) begin
      errs++;
      $display("FAIL err_r: got %h, want %h", r_obs, r_exp(er));
    end
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      vecs++;
      if (all_out !== '0) begin
        errs++;
        $display("FAIL err_idle[%0d]: outputs %h, want 0", i, all_out);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    ar_t ea;
    lsu_ar_addr  = 32'h8000_0100;
    lsu_ar_size  = 3'b010;
    lsu_ar_valid = 1'b1;
    out_ar_ready = 1'b1;
    ar_q.push_back('{lsu: 1'b1, addr: 32'h8000_0100, size: 3'b010});
    cyc();
    #1;
    vecs++;
    ea = ar_q.pop_front();
    if (ar_obs !== ar_exp(ea)) begin
      errs++;
      $display("FAIL rmid_ar: got %h, want %h", ar_obs, ar_exp(ea));
    end
    cyc();
    lsu_ar_valid = 1'b0;
    lsu_r_ready  = 1'b1;
    #1;
    vecs++;
    if (out_r_ready !== 1'b1) begin
      errs++;
      $display("FAIL rmid_in_r: out_r_ready %b, want 1", out_r_ready);
    end
    rstn = 1'b0;
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL rmid_async: outputs %h, want 0", all_out);
    end
    cyc();
    rstn = 1'b1;
    cyc();
    out_r_valid = 1'b1;
    out_r_data  = 32'h1111_2222;
    out_r_resp  = 2'b01;
    #1;
    vecs++;
    if (all_out !== '0) begin
      errs++;
      $display("FAIL rmid_late_r: outputs %h, want 0", all_out);
    end
    cyc();
    idle_inputs();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    idle_inputs();
    rstn = 1'b0;
    test_reset();
    test_ifu_alone();
    test_simultaneous();
    test_backpressure();
    test_error();
    test_reset_mid();
    vecs++;
    if (ar_q.size() != 0 || r_q.size() != 0) begin
      errs++;
      $display("FAIL scoreboard_drain: ar=%0d r=%0d left, want 0/0", ar_q.size(), r_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
